// File: rtl/frame_pingpong_rx.sv
// frame_pingpong_rx
// Double-buffered point-frame receiver. A byte stream is hunted for a run of
// SYNC_LEN zero bytes; the bytes that follow are assembled MSB-first into
// PW-bit points and written into the back bank of a two-bank RAM. A frame
// ends on DONE_WORD or when the bank fills. Completed frames are swapped to
// the front bank, which the drawing engine reads by index while the next
// frame is being received.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous active-high reset
//   rx_valid     one-cycle strobe qualifying rx_byte
//   rx_byte      received byte
//   done_drawing one-cycle pulse: engine finished with the front frame
//   rd_index     front-bank read address
//   rd_point     front-bank data at rd_index, one cycle latency
//   num_pts      point count of the front frame (0..DEPTH)
//   drawing      front bank holds a frame to draw
//   pending      back bank holds a committed frame waiting to be swapped in
//   overflow     one-cycle pulse: frame truncated at DEPTH points
//   dropped      one-cycle pulse: empty frame discarded
module frame_pingpong_rx #(
  parameter int DEPTH = 2048,
  parameter int AW = 11,
  parameter int BYTES = 4,
  parameter int SYNC_LEN = 8,
  parameter logic [8*BYTES-1:0] DONE_WORD = 32'h01010101,
  localparam int PW = 8*BYTES
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rx_valid,
  input  logic [7:0]    rx_byte,
  input  logic          done_drawing,
  input  logic [AW-1:0] rd_index,
  output logic [PW-1:0] rd_point,
  output logic [AW:0]   num_pts,
  output logic          drawing,
  output logic          pending,
  output logic          overflow,
  output logic          dropped
);

  localparam logic [1:0] ST_HUNT = 2'd0;
  localparam logic [1:0] ST_READ = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam int OW = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [OW-1:0] OFF_LAST  = OW'(BYTES - 1);
  localparam logic [OW-1:0] OFF_ONE   = OW'(1);
  localparam logic [AW:0]   CNT_FULL  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [3:0]    SYNC_LAST = 4'(SYNC_LEN - 1);

  logic [1:0]    state_q, state_d;
  logic [3:0]    zrun_q, zrun_d;
  logic [OW-1:0] off_q, off_d;
  logic [PW-1:0] asm_q, asm_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          sel_q, sel_d;
  logic [AW:0]   num_pts_q, num_pts_d;
  logic          drawing_q, drawing_d;
  logic          pending_q, pending_d;
  logic          overflow_q, overflow_d;
  logic          dropped_q, dropped_d;
  logic [PW-1:0] rd_point_q;

  logic          wr_en_s;
  logic [AW:0]   wr_addr_s;
  logic [PW-1:0] word_s;
  logic          end_s;
  logic [AW:0]   end_cnt_s;
  logic [AW:0]   next_cnt_s;

  logic [PW-1:0] mem [0:2*DEPTH-1];

  // Next-state logic for the receive FSM, bank swap and status outputs
  always_comb begin
    state_d    = state_q;
    zrun_d     = zrun_q;
    off_d      = off_q;
    asm_d      = asm_q;
    cnt_d      = cnt_q;
    sel_d      = sel_q;
    num_pts_d  = num_pts_q;
    pending_d  = pending_q;
    overflow_d = 1'b0;
    dropped_d  = 1'b0;
    wr_en_s    = 1'b0;
    wr_addr_s  = {~sel_q, cnt_q[AW-1:0]};
    // Shifting the whole register pushes stale upper bytes out once BYTES
    // bytes have arrived, so the register never needs clearing.
    word_s     = PW'({asm_q, rx_byte});
    end_s      = 1'b0;
    end_cnt_s  = cnt_q;
    next_cnt_s = cnt_q + CNT_ONE;

    // With nothing swapped in below, done_drawing retires the front frame;
    // any swap later in this block re-asserts drawing.
    if (done_drawing) begin
      drawing_d = 1'b0;
    end else begin
      drawing_d = drawing_q;
    end

    case (state_q)
      ST_HUNT: begin
        if (rx_valid) begin
          if (rx_byte == 8'h00) begin
            if (zrun_q == SYNC_LAST) begin
              state_d = ST_READ;
              zrun_d  = 4'd0;
              off_d   = {OW{1'b0}};
              cnt_d   = {(AW+1){1'b0}};
            end else begin
              zrun_d = zrun_q + 4'd1;
            end
          end else begin
            zrun_d = 4'd0;
          end
        end else begin
          zrun_d = zrun_q;
        end
      end
      ST_READ: begin
        if (rx_valid) begin
          if (off_q == OFF_LAST) begin
            off_d = {OW{1'b0}};
            if (word_s == DONE_WORD) begin
              end_s = 1'b1;
            end else begin
              wr_en_s = 1'b1;
              if (next_cnt_s == CNT_FULL) begin
                end_s      = 1'b1;
                end_cnt_s  = next_cnt_s;
                overflow_d = 1'b1;
              end else begin
                cnt_d = next_cnt_s;
              end
            end
          end else begin
            off_d = off_q + OFF_ONE;
            asm_d = word_s;
          end
        end else begin
          off_d = off_q;
        end
      end
      ST_HOLD: begin
        if (done_drawing) begin
          sel_d     = ~sel_q;
          num_pts_d = cnt_q;
          drawing_d = 1'b1;
          pending_d = 1'b0;
          state_d   = ST_HUNT;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_HUNT;
      end
    endcase

    // Frame end: discard empty frames, otherwise swap now or park in HOLD
    if (end_s) begin
      if (end_cnt_s == {(AW+1){1'b0}}) begin
        dropped_d = 1'b1;
        state_d   = ST_HUNT;
      end else if (!drawing_q || done_drawing) begin
        sel_d     = ~sel_q;
        num_pts_d = end_cnt_s;
        drawing_d = 1'b1;
        state_d   = ST_HUNT;
      end else begin
        pending_d = 1'b1;
        cnt_d     = end_cnt_s;
        state_d   = ST_HOLD;
      end
    end else begin
      end_cnt_s = cnt_q;
    end
  end

  // State and status registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_HUNT;
      zrun_q     <= 4'd0;
      off_q      <= {OW{1'b0}};
      asm_q      <= {PW{1'b0}};
      cnt_q      <= {(AW+1){1'b0}};
      sel_q      <= 1'b0;
      num_pts_q  <= {(AW+1){1'b0}};
      drawing_q  <= 1'b0;
      pending_q  <= 1'b0;
      overflow_q <= 1'b0;
      dropped_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      zrun_q     <= zrun_d;
      off_q      <= off_d;
      asm_q      <= asm_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      num_pts_q  <= num_pts_d;
      drawing_q  <= drawing_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      dropped_q  <= dropped_d;
    end
  end

  // Two-bank RAM: back-bank write on the completing byte, registered front read
  always_ff @(posedge clk) begin
    if (wr_en_s && !reset) begin
      mem[wr_addr_s] <= word_s;
    end
    rd_point_q <= mem[{sel_q, rd_index}];
  end

  assign rd_point = rd_point_q;
  assign num_pts  = num_pts_q;
  assign drawing  = drawing_q;
  assign pending  = pending_q;
  assign overflow = overflow_q;
  assign dropped  = dropped_q;

endmodule

// File: tb/tb_frame_pingpong_rx.sv
module tb_frame_pingpong_rx;

  localparam int DEPTH = 16;
  localparam int AW = 4;
  localparam int BYTES = 4;
  localparam int SYNC_LEN = 8;
  localparam logic [31:0] DONE_WORD = 32'h01010101;

  logic          clk = 1'b0;
  logic          reset;
  logic          rx_valid;
  logic [7:0]    rx_byte;
  logic          done_drawing;
  logic [AW-1:0] rd_index;
  logic [31:0]   rd_point;
  logic [AW:0]   num_pts;
  logic          drawing;
  logic          pending;
  logic          overflow;
  logic          dropped;

  frame_pingpong_rx #(
    .DEPTH(DEPTH), .AW(AW), .BYTES(BYTES), .SYNC_LEN(SYNC_LEN), .DONE_WORD(DONE_WORD)
  ) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .done_drawing(done_drawing), .rd_index(rd_index), .rd_point(rd_point),
    .num_pts(num_pts), .drawing(drawing), .pending(pending),
    .overflow(overflow), .dropped(dropped)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: frame-level view of the two banks
  logic [31:0] m_front[$];
  logic [31:0] m_back[$];
  logic [31:0] frame_q[$];
  bit          m_drawing = 1'b0;
  bit          m_pending = 1'b0;

  // Scoreboard queues
  logic [31:0]   rd_q[$];
  logic [AW+2:0] stat_q[$];   // {drawing, pending, num_pts}
  logic [1:0]    pulse_q[$];  // {overflow, dropped}
  logic rd_vld = 1'b0, rd_vld_d = 1'b0, stat_vld = 1'b0;

  always @(posedge clk) rd_vld_d <= rd_vld;

  // Monitor: pops expectations whenever the DUT presents data or a pulse
  always @(negedge clk) begin
    logic [31:0]   e_rd;
    logic [AW+2:0] e_st;
    logic [1:0]    e_pu;
    if (rd_vld_d) begin
      n_checks++;
      if (rd_q.size() == 0) begin
        n_errors++;
        $display("FAIL rd_point: read with no expectation, got %h", rd_point);
      end else begin
        e_rd = rd_q.pop_front();
        if (rd_point !== e_rd) begin
          n_errors++;
          $display("FAIL rd_point: got %h expected %h", rd_point, e_rd);
        end
      end
    end
    if (stat_vld && stat_q.size() > 0) begin
      e_st = stat_q.pop_front();
      n_checks += 3;
      if (drawing !== e_st[AW+2]) begin
        n_errors++;
        $display("FAIL drawing: got %b expected %b", drawing, e_st[AW+2]);
      end
      if (pending !== e_st[AW+1]) begin
        n_errors++;
        $display("FAIL pending: got %b expected %b", pending, e_st[AW+1]);
      end
      if (num_pts !== e_st[AW:0]) begin
        n_errors++;
        $display("FAIL num_pts: got %0d expected %0d", num_pts, e_st[AW:0]);
      end
    end
    if (overflow === 1'b1 || dropped === 1'b1) begin
      n_checks++;
      if (pulse_q.size() == 0) begin
        n_errors++;
        $display("FAIL pulse: unexpected overflow=%b dropped=%b", overflow, dropped);
      end else begin
        e_pu = pulse_q.pop_front();
        if ({overflow, dropped} !== e_pu) begin
          n_errors++;
          $display("FAIL pulse: got ovf/drop %b expected %b", {overflow, dropped}, e_pu);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_pt();
    logic [31:0] w;
    w = $urandom;
    if (w == DONE_WORD) w = w ^ 32'h1;
    return w;
  endfunction

  function automatic logic [31:0] noise_word();
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = 8'($urandom_range(1, 255));
    return w;
  endfunction

  // done_drawing as seen by the model
  task automatic model_dd();
    if (m_pending) begin
      m_front   = m_back;
      m_pending = 1'b0;
    end else begin
      m_drawing = 1'b0;
    end
  endtask

  // Outcome of frame_q (plus optional terminator) arriving in one go
  task automatic model_frame(input bit dd);
    int n;
    logic [31:0] nf[$];
    if (m_pending) begin
      if (dd) model_dd();
    end else begin
      n = (frame_q.size() >= DEPTH) ? DEPTH : frame_q.size();
      if (frame_q.size() >= DEPTH) pulse_q.push_back(2'b10);
      if (n == 0) begin
        pulse_q.push_back(2'b01);
        if (dd) model_dd();
      end else begin
        nf = {};
        for (int i = 0; i < n; i++) nf.push_back(frame_q[i]);
        if (!m_drawing || dd) begin
          m_front   = nf;
          m_drawing = 1'b1;
        end else begin
          m_back    = nf;
          m_pending = 1'b1;
        end
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit dd);
    repeat ($urandom_range(0, 1)) tick();
    rx_valid = 1'b1;
    rx_byte = b;
    done_drawing = dd;
    tick();
    rx_valid = 1'b0;
    rx_byte = 8'h00;
    done_drawing = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit dd_last);
    for (int k = 3; k >= 0; k--) send_byte(w[8*k +: 8], dd_last && (k == 0));
  endtask

  // Sync run, frame_q points, optional terminator (dd on its final byte)
  task automatic send_frame(input bit term, input bit dd);
    model_frame(dd);
    for (int z = 0; z < SYNC_LEN; z++) send_byte(8'h00, 1'b0);
    for (int i = 0; i < frame_q.size(); i++) send_word(frame_q[i], 1'b0);
    if (term) send_word(DONE_WORD, dd);
  endtask

  task automatic fill_random(input int n);
    frame_q = {};
    for (int i = 0; i < n; i++) frame_q.push_back(rand_pt());
  endtask

  task automatic dd_pulse();
    done_drawing = 1'b1;
    tick();
    done_drawing = 1'b0;
    model_dd();
  endtask

  task automatic check_status();
    stat_q.push_back({m_drawing, m_pending, (AW+1)'(m_front.size())});
    stat_vld = 1'b1;
    tick();
    stat_vld = 1'b0;
  endtask

  task automatic check_reads();
    for (int i = 0; i < m_front.size(); i++) begin
      rd_index = AW'(i);
      rd_q.push_back(m_front[i]);
      rd_vld = 1'b1;
      tick();
    end
    rd_vld = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_front = {};
    m_back = {};
    m_drawing = 1'b0;
    m_pending = 1'b0;
  endtask

  initial begin
    int sz;
    bit term;
    bit dd;
    reset = 1'b1;
    rx_valid = 1'b0;
    rx_byte = 8'h00;
    done_drawing = 1'b0;
    rd_index = '0;
    repeat (3) tick();
    reset = 1'b0;
    check_status();

    // Sync detection: a broken zero run must not open a frame
    for (int i = 0; i < 7; i++) send_byte(8'h00, 1'b0);
    send_byte(8'h05, 1'b0);
    frame_q = {32'h00A00B01, 32'h00C00D00};
    send_frame(1'b1, 1'b0);
    check_status();
    check_reads();

    // done_drawing with nothing pending: drawing drops, bank stays readable
    dd_pulse();
    check_status();
    check_reads();

    // Ping-pong: A draws while B is received and parked
    fill_random(3);
    send_frame(1'b1, 1'b0);
    check_status();
    fill_random(5);
    send_frame(1'b1, 1'b0);
    check_status();
    check_reads();
    fill_random(2);            // arrives during HOLD and is ignored
    send_frame(1'b1, 1'b0);
    check_status();
    dd_pulse();
    check_status();
    check_reads();

    // Overflow: 16 points fill the bank, 4 trailing words land in HUNT
    dd_pulse();
    fill_random(DEPTH);
    for (int i = 0; i < 4; i++) frame_q.push_back(noise_word());
    send_frame(1'b0, 1'b0);
    check_status();
    check_reads();

    // Empty frame
    frame_q = {};
    send_frame(1'b1, 1'b0);
    check_status();

    // Terminator coincides with done_drawing: immediate swap
    fill_random(4);
    send_frame(1'b1, 1'b1);
    check_status();
    check_reads();

    // Randomised frames and done_drawing pulses
    for (int it = 0; it < 14; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        dd_pulse();
      end else begin
        sz = $urandom_range(0, DEPTH);
        term = (sz < DEPTH);
        dd = term && ($urandom_range(0, 3) == 0);
        fill_random(sz);
        send_frame(term, dd);
      end
      check_status();
      check_reads();
    end

    // Reset after 2.5 points of a frame
    for (int z = 0; z < SYNC_LEN; z++) send_byte(8'h00, 1'b0);
    for (int i = 0; i < 10; i++) send_byte(8'($urandom_range(0, 255)), 1'b0);
    do_reset();
    check_status();
    fill_random(1);
    send_frame(1'b1, 1'b0);
    check_status();
    check_reads();

    repeat (3) tick();
    n_checks++;
    if (pulse_q.size() != 0) begin
      n_errors++;
      $display("FAIL pulse_missing: %0d expected pulses not seen, required 0", pulse_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/frame_pingpong_rx.md
# frame_pingpong_rx

Parametrised double-buffered point-frame receiver. Hunts a byte stream for a run of sync zeros, assembles fixed-width points MSB-first, and stores them in the back half of a two-bank RAM. Frames end on a terminator word or when the bank fills, and completed frames swap to the front bank. The vector drawing engine reads the front bank by index while the next frame is received, so there is no dead time between frames.

## Interface
- `DEPTH`, 2048, points per bank (power of two).
- `AW`, 11, index width; `2**AW == DEPTH`.
- `BYTES`, 4, bytes per point; point width `PW = 8*BYTES`.
- `SYNC_LEN`, 8, consecutive 0x00 bytes that open a frame (2..15).
- `DONE_WORD`, 32'h01010101, terminator value (`PW` bits).
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rx_valid`  in  1  one-cycle strobe: `rx_byte` valid.
- `rx_byte`  in  8  received byte.
- `done_drawing`  in  1  one-cycle pulse: engine finished the front frame.
- `rd_index`  in  AW  front-bank read address.
- `rd_point`  out  PW  front-bank data at `rd_index`, registered.
- `num_pts`  out  AW+1  point count of the front frame (0..DEPTH).
- `drawing`  out  1  front bank holds a frame to draw.
- `pending`  out  1  back bank holds a committed frame awaiting swap.
- `overflow`  out  1  one-cycle pulse: frame truncated at DEPTH.
- `dropped`  out  1  one-cycle pulse: frame discarded.

## Operation
- Receive FSM: HUNT -> READ -> HOLD.
  - HUNT: the zero-run counter increments on each `rx_byte==0`, and any nonzero byte clears it. When the counter reaches SYNC_LEN, the FSM enters READ with write pointer 0, byte offset 0 and count 0.
  - READ: each byte shifts into the assembly register (first byte becomes the MSB). On byte BYTES the word is complete:
    - if the word equals `DONE_WORD`, the frame ends;
    - otherwise the word is written to back[count] and count increments.
    - When count reaches DEPTH after a write, the frame ends and `overflow` pulses.
    - Zero bytes inside READ are data; they do not resync.
  - Frame end with count 0: pulse `dropped` and return to HUNT.
  - Frame end with count > 0: commit.
    - If `drawing==0`, or `done_drawing` is high this same cycle, swap immediately and return to HUNT.
    - Otherwise go to HOLD with `pending=1`.
  - HOLD: `rx_valid` bytes are ignored. On `done_drawing`, swap, clear `pending` and go to HUNT.
- Swap: toggle the bank-select bit, load `num_pts` with the committed count, set `drawing=1`.
- `done_drawing` with no pending frame: `drawing` goes to 0. `num_pts` and the bank are held, and the bank stays readable.
- `done_drawing` while `drawing==0`: ignored.
- RAM: 2*DEPTH x PW. Write port address is {~sel, wptr}; read port address is {sel, rd_index}.

## Timing
- Reset values: `drawing=0`, `pending=0`, `num_pts=0`, `overflow=0`, `dropped=0`, sel=0, FSM=HUNT, zero-run=0, offset=0. `rd_point` is undefined until the first read after reset. RAM contents are not cleared.
- Reset takes priority over every input in the same cycle. Reset mid-frame discards the partial frame.
- Read latency: `rd_point` reflects the `rd_index` sampled one cycle earlier, from the bank selected in that earlier cycle.
- Write: the RAM write occurs in the cycle after the completing `rx_valid`. Back-to-back `rx_valid` on every cycle is supported.
- Commit or swap on the completing byte: `drawing`, `num_pts` and sel update one cycle after that `rx_valid`. The write of the last point lands no later than the swap.
- HOLD swap: `drawing`/`num_pts`/sel update one cycle after `done_drawing`. `pending` falls on the same edge.
- `overflow` and `dropped` are high for exactly one cycle, one cycle after the completing byte.

## Test plan
- Sync detection: send 7 zeros, 0x05, then 8 zeros, then points 0x00A00B01 and 0x00C00D00, then DONE_WORD. Require `drawing=1` and `num_pts=2`. Require `rd_index=0 -> rd_point=0x00A00B01` one cycle later, and `rd_index=1 -> 0x00C00D00`.
- Ping-pong: while frame A (3 pts) is drawing, receive frame B (5 pts). Require `pending=1`, `num_pts=3`, and unchanged A data. On `done_drawing`, require `num_pts=5`, `pending=0`, and B data at indices 0..4.
- Overflow: with `DEPTH=16`, stream 20 points and no terminator. Require one `overflow` pulse after point 16 and `num_pts=16`. The trailing 4 words are treated as HUNT bytes.
- Empty frame: sync followed immediately by DONE_WORD. Require a `dropped` pulse and unchanged `drawing` and `num_pts`.
- Simultaneous events: the final DONE byte arrives in the same cycle as `done_drawing`. Require an immediate swap with `pending` never asserted. Separately, `done_drawing` with nothing pending must drop `drawing` to 0.
- Reset mid-frame: assert reset after 2.5 points of a frame. Require all outputs at their reset values. A fresh sync plus 1 point plus DONE must then give `num_pts=1` with `sel` at bank 1.
